// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, default lane count and requant FSM states
package pe_pkg;
  localparam int PSUM_W    = 32;
  localparam int ACT_W     = 8;
  localparam int MULT_W    = 16;
  localparam int NUM_LANES = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/requant_lane.sv
// requant_lane: int32 psum to int8 via multiply, round, shift, saturate; ReLU when PSUM_REQUANT_RELU_EN is defined
module requant_lane import pe_pkg::*; (
  input  logic [PSUM_W-1:0] psum,
  input  logic [MULT_W-1:0] mult,
  input  logic [4:0]        shift,
  output logic [ACT_W-1:0]  q
);
  logic signed [48:0] prod, rnd, shf;
  logic [ACT_W-1:0] sat;
  // 49-bit signed path holds the full product plus rounding bias without wrapping
  always_comb begin
    prod = 49'(signed'(psum)) * 49'(signed'(mult));
    rnd  = prod + ((shift == 5'd0) ? 49'sd0 : (49'sd1 <<< (shift - 5'd1)));
    shf  = rnd >>> shift;
    sat  = (shf > 49'sd127) ? 8'h7f : (shf < -49'sd128) ? 8'h80 : shf[ACT_W-1:0];
  end
`ifdef PSUM_REQUANT_RELU_EN
  assign q = sat[ACT_W-1] ? '0 : sat;
`else
  assign q = sat;
`endif
endmodule

// File: rtl/psum_requant.sv
// psum_requant: streams psum words through per-lane requant into a credit-guarded output FIFO; ReLU when PSUM_REQUANT_RELU_EN is defined
module psum_requant import pe_pkg::*; #(
  parameter int LANES      = NUM_LANES,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [15:0]               cfg_num_pix,
  input  logic [15:0]               cfg_mult,
  input  logic [4:0]                cfg_shift,
  input  logic [15:0]               cfg_base,
  output logic                      psum_en,
  output logic [9:0]                psum_addr,
  input  logic [LANES*PSUM_W-1:0]   psum_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACT_W-1:0]    out_data,
  output logic [15:0]               out_addr,
  output logic                      busy,
  output logic                      done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = LANES * ACT_W;

  state_t state;
  logic [15:0] num, base, idx, widx, acc;
  logic [MULT_W-1:0] mult;
  logic [4:0] shift;
  logic [RD_LAT-1:0] dly;
  logic rq_v, pop, issue, go;
  logic [LANES*PSUM_W-1:0] rq_data;
  logic [DW-1:0] q;
  logic [16+DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt, infl;

  assign go        = state == IDLE && start && cfg_num_pix != 16'd0;
  assign pop       = out_valid && out_ready;
  // a word leaving this cycle already frees its slot, which sustains one word per cycle
  assign issue     = go || (state == RUN && idx < num &&
                     int'(cnt) + int'(infl) - int'(pop) < FIFO_DEPTH);
  assign out_valid = cnt != '0;
  assign out_data  = out_valid ? mem[rp][DW-1:0] : '0;
  assign out_addr  = out_valid ? mem[rp][16+DW-1:DW] : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .psum  (rq_data[i*PSUM_W +: PSUM_W]),
      .mult  (mult),
      .shift (shift),
      .q     (q[i*ACT_W +: ACT_W])
    );
  end

  // job sequencing: config latch, read issue, in-flight credit and completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      psum_en   <= 1'b0;
      psum_addr <= '0;
      num       <= '0;
      base      <= '0;
      mult      <= '0;
      shift     <= '0;
      idx       <= '0;
      widx      <= '0;
      acc       <= '0;
      infl      <= '0;
    end else begin
      done    <= 1'b0;
      psum_en <= issue;
      infl    <= infl + CW'(issue) - CW'(rq_v);
      if (issue) begin
        psum_addr <= go ? 10'd0 : idx[9:0];
        idx       <= go ? 16'd1 : idx + 16'd1;
      end
      if (rq_v) widx <= widx + 16'd1;
      if (pop) acc <= acc + 16'd1;
      case (state)
        IDLE: if (start) begin
          num   <= cfg_num_pix;
          mult  <= cfg_mult;
          shift <= cfg_shift;
          base  <= cfg_base;
          acc   <= '0;
          widx  <= '0;
          busy  <= cfg_num_pix != 16'd0;
          done  <= cfg_num_pix == 16'd0;
          state <= cfg_num_pix == 16'd0 ? IDLE : cfg_num_pix == 16'd1 ? DRAIN : RUN;
        end
        RUN: if (issue && idx == num - 16'd1) state <= DRAIN;
        DRAIN: if (pop && acc == num - 16'd1) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read-latency tracking, requant register and output FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly  <= '0;
      rq_v <= 1'b0;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
    end else begin
      dly[0] <= psum_en;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
      rq_v <= dly[RD_LAT-1];
      if (dly[RD_LAT-1]) rq_data <= psum_rdata;
      if (rq_v) begin
        mem[wp] <= {base + widx, q};
        wp      <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      if (pop) rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
      cnt <= cnt + CW'(rq_v) - CW'(pop);
    end
  end
endmodule
